// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor output cycles, buffers snapshots
// in a FIFO and drains them as variable-length 64-bit word records.
`default_nettype none

module verdict_collector #(
    parameter int NUM_OUT = 4,
    parameter int DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_OUT*64-1:0] out_data,
    input  logic [NUM_OUT-1:0]    out_aktv,
    output logic [63:0]           m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_TS   = 2'd1;
    localparam logic [1:0] c_MASK = 2'd2;
    localparam logic [1:0] c_DATA = 2'd3;

    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [63:0]           ts_q;
    logic [c_AW:0]         wr_ptr_q;
    logic [c_AW:0]         rd_ptr_q;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [c_IW-1:0]       idx_q;
    logic [c_IW-1:0]       idx_d;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q;

    logic [63:0]           mem_ts_q   [DEPTH];
    logic [NUM_OUT-1:0]    mem_aktv_q [DEPTH];
    logic [NUM_OUT*64-1:0] mem_data_q [DEPTH];
    logic [15:0]           mem_drop_q [DEPTH];

    logic [c_AW-1:0]       w_rd_addr;
    logic [c_AW-1:0]       w_wr_addr;
    logic [63:0]           w_head_ts;
    logic [NUM_OUT-1:0]    w_head_aktv;
    logic [NUM_OUT*64-1:0] w_head_data;
    logic [15:0]           w_head_drop;
    logic [63:0]           w_mask_word;
    logic [c_AW:0]         w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_more_after_pop;
    logic [c_IW-1:0]       w_first_idx;
    logic [c_IW-1:0]       w_next_idx;
    logic                  w_has_next;

    assign w_rd_addr   = rd_ptr_q[c_AW-1:0];
    assign w_wr_addr   = wr_ptr_q[c_AW-1:0];
    assign w_head_ts   = mem_ts_q[w_rd_addr];
    assign w_head_aktv = mem_aktv_q[w_rd_addr];
    assign w_head_data = mem_data_q[w_rd_addr];
    assign w_head_drop = mem_drop_q[w_rd_addr];

    assign w_count = wr_ptr_q - rd_ptr_q;
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);

    assign w_xfer     = m_valid && m_ready;
    assign w_pop      = (state_q == c_DATA) && w_xfer && !w_has_next;
    assign w_push_req = en && (|out_aktv);
    // A full FIFO still takes the snapshot when the head leaves on this edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_more_after_pop = (w_count != c_PTR_ONE) || w_push;

    always_comb begin
        w_first_idx = '0;
        w_next_idx  = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (w_head_aktv[i]) begin
                w_first_idx = c_IW'(i);
            end
            if (w_head_aktv[i] && (i > int'(idx_q))) begin
                w_next_idx = c_IW'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_mask_word                = '0;
        w_mask_word[NUM_OUT-1:0]   = w_head_aktv;
        w_mask_word[47:32]         = w_head_drop;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            c_IDLE: begin
                if (!w_empty || w_push) begin
                    state_d = c_TS;
                end
            end
            c_TS: begin
                if (w_xfer) begin
                    state_d = c_MASK;
                end
            end
            c_MASK: begin
                if (w_xfer) begin
                    state_d = c_DATA;
                    idx_d   = w_first_idx;
                end
            end
            c_DATA: begin
                if (w_xfer) begin
                    if (w_has_next) begin
                        idx_d = w_next_idx;
                    end else begin
                        state_d = w_more_after_pop ? c_TS : c_IDLE;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        m_data = '0;
        case (state_q)
            c_TS:    m_data = w_head_ts;
            c_MASK:  m_data = w_mask_word;
            c_DATA:  m_data = w_head_data[{idx_q, 6'b0} +: 64];
            default: m_data = '0;
        endcase
    end

    assign m_valid  = (state_q != c_IDLE);
    assign m_last   = (state_q == c_DATA) && !w_has_next;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= c_IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (en) begin
                ts_q <= ts_q + 64'd1;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            if (w_drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_ts_q[w_wr_addr]   <= ts_q;
            mem_aktv_q[w_wr_addr] <= out_aktv;
            mem_data_q[w_wr_addr] <= out_data;
            mem_drop_q[w_wr_addr] <= drop_cnt_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: table-driven record checks plus directed multi-cycle
// sequences for backpressure, overflow, same-edge push/pop, enable and reset.
`default_nettype none

module tb_verdict_collector;

    logic         clk;
    logic         rst;
    logic         en;
    logic [255:0] out_data;
    logic [3:0]   out_aktv;
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         overflow;
    logic [15:0]  drop_cnt;

    verdict_collector #(.NUM_OUT(4), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out_data (out_data),
        .out_aktv (out_aktv),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  aktv;
        logic [63:0] d [4];
        logic [63:0] w [6];
        int          len;
    } vec_t;

    vec_t        tbl [5];
    logic [64:0] got   [$];
    logic [64:0] exp_q [$];
    int          checks;
    int          errors;
    int          vcyc;
    int          last_ticks;
    logic        held;
    logic [64:0] held_v;

    localparam logic [63:0] c_M2 = 64'h0000_0002_0000_0000;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] a, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
        out_aktv = a;
        out_data = {d3, d2, d1, d0};
    endtask

    task automatic expw(input logic last, input logic [63:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic tick();
        if (m_valid && m_ready) got.push_back({m_last, m_data});
        if (m_valid) vcyc++;
        held   = m_valid && !m_ready && rst;
        held_v = {m_last, m_data};
        @(posedge clk);
        #1;
        if (held && rst) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", {m_last, m_data}, held_v);
        end
    endtask

    task automatic cmp_got(input int n);
        chk("rec_len", 65'(got.size()), 65'(n));
        for (int k = 0; k < n && k < got.size() && k < exp_q.size(); k++) begin
            chk($sformatf("word%0d", k), got[k], exp_q[k]);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic drain(input int n, input int bound);
        int t;
        t = 0;
        while (got.size() < n && t < bound) begin
            tick();
            t++;
        end
        last_ticks = t;
        cmp_got(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; vcyc = 0; last_ticks = 0; held = 0; held_v = '0;
        rst = 1'b0; en = 1'b0; m_ready = 1'b0; out_data = '0; out_aktv = '0;

        tbl[0].aktv = 4'b0101; tbl[0].len = 4;
        tbl[0].d = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 64'd11};
        tbl[0].w = '{64'd10, 64'd5, 64'd7, 64'd9, 64'd0, 64'd0};
        tbl[1].aktv = 4'b1111; tbl[1].len = 6;
        tbl[1].d = '{64'd1, 64'd2, 64'd3, 64'd4};
        tbl[1].w = '{64'd15, 64'hF, 64'd1, 64'd2, 64'd3, 64'd4};
        tbl[2].aktv = 4'b1000; tbl[2].len = 3;
        tbl[2].d = '{64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2].w = '{64'd22, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0};
        tbl[3].aktv = 4'b0001; tbl[3].len = 3;
        tbl[3].d = '{64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0};
        tbl[3].w = '{64'd26, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0};
        tbl[4].aktv = 4'b0110; tbl[4].len = 4;
        tbl[4].d = '{64'd5, 64'd6, 64'd7, 64'd8};
        tbl[4].w = '{64'd30, 64'd6, 64'd6, 64'd7, 64'd0, 64'd0};

        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Record format table, m_ready held high
        en = 1'b1;
        repeat (10) tick();
        m_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            got.delete();
            set_in(tbl[v].aktv, tbl[v].d[0], tbl[v].d[1], tbl[v].d[2], tbl[v].d[3]);
            tick();
            out_aktv = 4'b0000;
            chk("lat_valid", m_valid, 1'b1);
            chk("lat_ts", m_data, tbl[v].w[0]);
            for (int k = 0; k < tbl[v].len; k++) expw(k == tbl[v].len - 1, tbl[v].w[k]);
            vcyc = 0;
            drain(tbl[v].len, 20);
            chk("valid_cycles", 65'(vcyc), 65'(tbl[v].len));
            chk("idle_after", m_valid, 1'b0);
        end

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        got.delete();
        set_in(4'b0101, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 64'd11);
        tick();
        out_aktv = 4'b0000;
        expw(0, 64'd35); expw(0, 64'd5); expw(0, 64'd7); expw(1, 64'd9);
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            m_ready = (i % 3 == 0);
            tick();
        end
        cmp_got(4);
        m_ready = 1'b1;

        // Overflow with m_ready low
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        m_ready = 1'b0; en = 1'b1;
        set_in(4'b0001, 64'h55, 64'd0, 64'd0, 64'd0);
        repeat (8) tick();
        chk("ovf8_drop", drop_cnt, 16'd0);
        chk("ovf8_flag", overflow, 1'b0);
        tick();
        chk("ovf9_drop", drop_cnt, 16'd1);
        chk("ovf9_flag", overflow, 1'b1);
        tick();
        chk("ovf10_drop", drop_cnt, 16'd2);
        en = 1'b0; out_aktv = 4'b0000; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expw(0, 64'(i)); expw(0, 64'd1); expw(1, 64'h55);
        end
        drain(24, 40);
        chk("ovf_throughput", 65'(last_ticks), 65'd24);

        // Full FIFO, push coinciding with last-word pop
        en = 1'b1; m_ready = 1'b0;
        set_in(4'b0001, 64'h66, 64'd0, 64'd0, 64'd0);
        repeat (8) tick();
        chk("fill_drop", drop_cnt, 16'd2);
        out_aktv = 4'b0000; m_ready = 1'b1;
        tick(); tick();
        chk("full_last", m_last, 1'b1);
        set_in(4'b0001, 64'h77, 64'd0, 64'd0, 64'd0);
        tick();
        out_aktv = 4'b0000;
        chk("full_drop", drop_cnt, 16'd2);
        chk("full_ovf", overflow, 1'b1);
        for (int i = 10; i < 18; i++) begin
            expw(0, 64'(i)); expw(0, c_M2 | 64'd1); expw(1, 64'h66);
        end
        expw(0, 64'd20); expw(0, c_M2 | 64'd1); expw(1, 64'h77);
        drain(27, 60);

        // Enable gating: pending record drains while en=0, ts holds
        m_ready = 1'b0; en = 1'b1;
        set_in(4'b0010, 64'd0, 64'h99, 64'd0, 64'd0);
        tick();
        en = 1'b0; m_ready = 1'b1;
        set_in(4'b0011, 64'd1, 64'd2, 64'd0, 64'd0);
        repeat (5) tick();
        chk("gate_idle", m_valid, 1'b0);
        expw(0, 64'd45); expw(0, c_M2 | 64'd2); expw(1, 64'h99);
        cmp_got(3);
        en = 1'b1;
        set_in(4'b0001, 64'hAA, 64'd0, 64'd0, 64'd0);
        tick();
        out_aktv = 4'b0000;
        expw(0, 64'd46); expw(0, c_M2 | 64'd1); expw(1, 64'hAA);
        drain(3, 10);

        // Reset in the DATA state
        en = 1'b1; m_ready = 1'b0;
        set_in(4'b1111, 64'd1, 64'd2, 64'd3, 64'd4);
        tick();
        set_in(4'b0001, 64'd5, 64'd0, 64'd0, 64'd0);
        tick();
        out_aktv = 4'b0000; m_ready = 1'b1;
        tick(); tick();
        chk("mid_valid", m_valid, 1'b1);
        chk("mid_data", m_data, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", m_valid, 1'b0);
        chk("arst_last", m_last, 1'b0);
        chk("arst_data", m_data, 64'd0);
        got.delete();
        tick(); tick();
        rst = 1'b1;
        en = 1'b0;
        repeat (5) tick();
        chk("stale_words", 65'(got.size()), 65'd0);
        chk("post_ovf", overflow, 1'b0);
        chk("post_drop", drop_cnt, 16'd0);
        en = 1'b1;
        set_in(4'b0001, 64'hBB, 64'd0, 64'd0, 64'd0);
        tick();
        out_aktv = 4'b0000;
        expw(0, 64'd0); expw(0, 64'd1); expw(1, 64'hBB);
        drain(3, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/verdict_collector.md
# verdict_collector

Capture block on the output side of the generated `topEntity` monitor. Samples the monitor's output streams and their `_aktv` flags every cycle, timestamps any cycle with at least one active output, buffers the snapshot in a FIFO and drains it as variable-length 64-bit word records over a valid/ready stream. It is the hardware counterpart of the stimulus path: the testbench and host feed inputs into the monitor, and this block carries verdicts back out.

## Interface

Parameters:
- `NUM_OUT`, 4: number of monitor output streams, 1..16.
- `DEPTH`, 8: snapshot FIFO depth in entries, power of two, ≥2.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-low (0 = reset).
- `en`, in, 1: capture and timestamp enable.
- `out_data`, in, NUM_OUT*64: monitor outputs, stream i in bits [64i+63:64i], signed.
- `out_aktv`, in, NUM_OUT: per-stream active flags.
- `m_data`, out, 64: record word.
- `m_valid`, out, 1: word valid.
- `m_ready`, in, 1: consumer accepts the word.
- `m_last`, out, 1: final word of a record.
- `overflow`, out, 1: sticky flag, set when a snapshot is dropped.
- `drop_cnt`, out, 16: dropped snapshots, saturates at 16'hFFFF.

## Operation

- **Timestamp counter.** 64-bit free-running counter `ts`.
  - Reset value 0.
  - Increments on each rising edge with `en`=1; holds while `en`=0.
  - Wraps from 2^64-1 to 0.
- **Capture.** On a rising edge with `en`=1 and `|out_aktv`=1, push {`ts` pre-increment value, `out_aktv`, `out_data`, `drop_cnt`} into the FIFO.
  - The first enabled edge after reset carries ts=0.
  - No push while `en`=0.
- **Full FIFO.** A push into a full FIFO is accepted only when the head entry pops on the same edge. Otherwise the snapshot is dropped: `overflow` is set and `drop_cnt` increments, saturating.
- **Record format.** Each record is 2+popcount(aktv) words:
  - Word 0: timestamp.
  - Word 1: bits[NUM_OUT-1:0]=aktv, bits[47:32]=drop_cnt at capture, all other bits 0.
  - Words 2..: `out_data` of each active stream in ascending index order, passed unchanged.
  - `m_last`=1 only on the final word.
- **Serializer FSM.** States IDLE, TS, MASK, DATA.
  - IDLE→TS when the FIFO is non-empty.
  - TS→MASK on handshake.
  - MASK→DATA on handshake.
  - In DATA, step to the next set aktv bit on each handshake. After the highest set bit is accepted, pop the entry, then go to TS if the FIFO is still non-empty, otherwise IDLE.
  - The FSM reads the FIFO head in place; the entry pops only on the last-word handshake.
- **Handshake.** A transfer happens on a rising edge with `m_valid`=1 and `m_ready`=1.
  - Once asserted, `m_data`, `m_valid` and `m_last` stay stable until the transfer completes.
  - `m_valid` never drops without a transfer.
  - `m_ready` may be high before `m_valid`.
- **Enable.** `en` does not gate the serializer; draining continues while `en`=0.
- **Reset values.** `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `drop_cnt`=0, FIFO empty, FSM IDLE.
  - Reset assertion takes effect immediately, without waiting for a clock edge.
  - A reset mid-record discards the partial record and all buffered entries.

## Timing

- **Capture-to-output latency.** With an empty FIFO and IDLE serializer, a snapshot captured at edge E puts word 0 on `m_data` with `m_valid`=1 after E. It is transferable at edge E+1.
- **Throughput.** With `m_ready` held at 1, one word per cycle, and back-to-back records have no idle cycle between them.
- **Sustained capture.** With `m_ready`=1 and `en`=1, the block sustains one capture every 2+popcount cycles without loss.
- **Simultaneous push and last-word pop on a full FIFO.** The push succeeds and the count is unchanged.
- **Outputs.** `overflow` and `drop_cnt` are registered and update on the edge after the drop.
- **Datapath width.** No arithmetic on the data path; only `ts`, `drop_cnt` and the FIFO pointers count. Pointers are log2(DEPTH)+1 bits for full/empty detection.

## Test plan

- **Single capture.** NUM_OUT=4, after reset run 10 enabled edges, then aktv=4'b0101 with outputs (7,-3,9,11), `m_ready`=1 → words 10, 0x5, 7, 9. `m_last` is high on the word 9. `m_valid` is high in exactly 4 consecutive cycles.
- **Backpressure.** Same stimulus with `m_ready` toggling 1,0,0,1,… → identical word sequence. `m_data` is stable whenever `m_valid`=1 and `m_ready`=0.
- **Overflow.** DEPTH=8, `m_ready`=0, aktv=4'b0001 for 10 consecutive cycles → 8 records stored, `overflow`=1, `drop_cnt`=2. After releasing `m_ready`, the first record's mask word shows drop_cnt 0.
- **Full FIFO, same-edge push and pop.** Fill to DEPTH. Release `m_ready` so a last word transfers on the same edge as a new capture → capture accepted, `drop_cnt` unchanged.
- **Enable gating.** `en`=0 for 5 cycles with aktv active → no records pushed, `ts` frozen. Pending records still drain. After re-enable, the next timestamp continues from the held value.
- **Reset mid-record.** Assert `rst`=0 in the middle of the DATA state → `m_valid`=0 at once, with no clock edge needed. After release, `ts` restarts at 0, `overflow`=0, and no stale words appear.
